// File: rtl/sdc_cmd_master.sv
`default_nettype none
`timescale 1ns/1ps
// +--------------------------------------------------------------------------+
// | sdc_cmd_master : Wishbone master issuing one SD command per request,     |
// | polling the event register and fetching the 120-bit response.            |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module sdc_cmd_master #(
    parameter int POLL_W    = 16,
    parameter int GAP_W     = 3,
    parameter int READ_RESP = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         req_valid,
    output logic         req_ready,
    input  logic [13:0]  req_cmd,
    input  logic [31:0]  req_arg,
    output logic         done,
    output logic [4:0]   status,
    output logic         timeout,
    output logic [119:0] resp,
    output logic [7:0]   wb_addr,
    output logic [31:0]  wb_dout,
    input  logic [31:0]  wb_din,
    output logic [3:0]   wb_dm,
    output logic         wb_cyc,
    output logic         wb_stb,
    output logic         wb_we,
    input  logic         wb_ack
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_WR_CMD = 3'd1,
        S_WR_ARG = 3'd2,
        S_POLL   = 3'd3,
        S_WAIT   = 3'd4,
        S_CLEAR  = 3'd5,
        S_RESP   = 3'd6,
        S_DONE   = 3'd7
    } state_t;

    localparam logic [POLL_W-1:0] c_poll_one  = POLL_W'(1);
    localparam logic [POLL_W-1:0] c_poll_max  = '1;
    localparam logic [POLL_W-1:0] c_poll_last = c_poll_max - c_poll_one;
    localparam logic [GAP_W-1:0]  c_gap_one   = GAP_W'(1);
    localparam logic [GAP_W-1:0]  c_gap_max   = '1;
    localparam logic [GAP_W-1:0]  c_gap_last  = c_gap_max - c_gap_one;

    state_t              r_state, w_state;
    logic [13:0]         r_cmd, w_cmd;
    logic [31:0]         r_arg, w_arg;
    logic [POLL_W-1:0]   r_poll_cnt, w_poll_cnt;
    logic [GAP_W-1:0]    r_gap_cnt, w_gap_cnt;
    logic [1:0]          r_idx, w_idx;
    logic [4:0]          r_status, w_status;
    logic                r_timeout, w_timeout;
    logic [119:0]        r_resp, w_resp;
    logic                r_cyc, w_cyc;
    logic                r_we, w_we;
    logic [7:0]          r_addr, w_addr;
    logic [31:0]         r_dout, w_dout;
    logic [40:0]         w_setup;

    // {we, addr, dout} presented for the bus cycle belonging to a state.
    function automatic logic [40:0] bus_setup(input state_t s, input logic [1:0] idx,
                                              input logic [13:0] cmd, input logic [31:0] arg);
        case (s)
            S_WR_CMD: bus_setup = {1'b1, 8'h04, 18'b0, cmd};
            S_WR_ARG: bus_setup = {1'b1, 8'h00, arg};
            S_POLL:   bus_setup = {1'b0, 8'h34, 32'h0};
            S_CLEAR:  bus_setup = {1'b1, 8'h34, 32'h0};
            S_RESP:   bus_setup = {1'b0, 8'h08 + {4'b0, idx, 2'b00}, 32'h0};
            default:  bus_setup = '0;
        endcase
    endfunction

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state    <= S_IDLE;
            r_cmd      <= '0;
            r_arg      <= '0;
            r_poll_cnt <= '0;
            r_gap_cnt  <= '0;
            r_idx      <= '0;
            r_status   <= '0;
            r_timeout  <= 1'b0;
            r_resp     <= '0;
            r_cyc      <= 1'b0;
            r_we       <= 1'b0;
            r_addr     <= '0;
            r_dout     <= '0;
        end else begin
            r_state    <= w_state;
            r_cmd      <= w_cmd;
            r_arg      <= w_arg;
            r_poll_cnt <= w_poll_cnt;
            r_gap_cnt  <= w_gap_cnt;
            r_idx      <= w_idx;
            r_status   <= w_status;
            r_timeout  <= w_timeout;
            r_resp     <= w_resp;
            r_cyc      <= w_cyc;
            r_we       <= w_we;
            r_addr     <= w_addr;
            r_dout     <= w_dout;
        end
    end

    always_comb begin
        w_state    = r_state;
        w_cmd      = r_cmd;
        w_arg      = r_arg;
        w_poll_cnt = r_poll_cnt;
        w_gap_cnt  = r_gap_cnt;
        w_idx      = r_idx;
        w_status   = r_status;
        w_timeout  = r_timeout;
        w_resp     = r_resp;
        w_cyc      = r_cyc;
        w_we       = r_we;
        w_addr     = r_addr;
        w_dout     = r_dout;
        w_setup    = bus_setup(r_state, r_idx, r_cmd, r_arg);
        case (r_state)
            S_IDLE: begin
                if (req_valid) begin
                    w_cmd      = req_cmd;
                    w_arg      = req_arg;
                    w_status   = '0;
                    w_timeout  = 1'b0;
                    w_resp     = '0;
                    w_poll_cnt = '0;
                    w_gap_cnt  = '0;
                    w_idx      = '0;
                    w_state    = S_WR_CMD;
                end
            end
            S_WR_CMD, S_WR_ARG, S_POLL, S_CLEAR, S_RESP: begin
                // A bus state is entered with cyc low; that cycle is the inter-transfer gap.
                if (!r_cyc) begin
                    w_cyc = 1'b1;
                    {w_we, w_addr, w_dout} = w_setup;
                end else if (wb_ack) begin
                    w_cyc  = 1'b0;
                    w_we   = 1'b0;
                    w_addr = '0;
                    w_dout = '0;
                    case (r_state)
                        S_WR_CMD: w_state = S_WR_ARG;
                        S_WR_ARG: w_state = S_POLL;
                        S_POLL: begin
                            if (wb_din[4:0] != 5'd0) begin
                                w_status = wb_din[4:0];
                                w_state  = S_CLEAR;
                            end else if (r_poll_cnt == c_poll_last) begin
                                w_poll_cnt = c_poll_max;
                                w_timeout  = 1'b1;
                                w_status   = '0;
                                w_state    = S_CLEAR;
                            end else begin
                                w_poll_cnt = r_poll_cnt + c_poll_one;
                                w_gap_cnt  = '0;
                                w_state    = S_WAIT;
                            end
                        end
                        S_CLEAR: begin
                            if ((READ_RESP != 0) && !r_timeout && (r_status[4:1] == 4'd0))
                                w_state = S_RESP;
                            else
                                w_state = S_DONE;
                        end
                        S_RESP: begin
                            case (r_idx)
                                2'd0:    w_resp[31:0]   = wb_din;
                                2'd1:    w_resp[63:32]  = wb_din;
                                2'd2:    w_resp[95:64]  = wb_din;
                                default: w_resp[119:96] = wb_din[23:0];
                            endcase
                            if (r_idx == 2'd3)
                                w_state = S_DONE;
                            else
                                w_idx = r_idx + 2'd1;
                        end
                        default: w_state = S_IDLE;
                    endcase
                end
            end
            S_WAIT: begin
                // The idle gap absorbs the normal one-cycle gap: the poll starts straight away.
                if (r_gap_cnt == c_gap_last) begin
                    w_gap_cnt = '0;
                    w_state   = S_POLL;
                    w_cyc     = 1'b1;
                    {w_we, w_addr, w_dout} = bus_setup(S_POLL, r_idx, r_cmd, r_arg);
                end else begin
                    w_gap_cnt = r_gap_cnt + c_gap_one;
                end
            end
            S_DONE:  w_state = S_IDLE;
            default: w_state = S_IDLE;
        endcase
    end

    assign req_ready = (r_state == S_IDLE);
    assign done      = (r_state == S_DONE);
    assign status    = r_status;
    assign timeout   = r_timeout;
    assign resp      = r_resp;
    assign wb_cyc    = r_cyc;
    assign wb_stb    = r_cyc;
    assign wb_we     = r_we;
    assign wb_addr   = r_addr;
    assign wb_dout   = r_dout;
    assign wb_dm     = 4'hF;

endmodule
`default_nettype wire

// File: tb/tb_sdc_cmd_master.sv
`default_nettype none
`timescale 1ns/1ps
// Randomized self-checking bench for sdc_cmd_master: a Wishbone slave model with
// configurable wait states, a bus monitor and a transaction-level reference model.
module tb_sdc_cmd_master;

    localparam int POLL_W    = 3;
    localparam int GAP_W     = 3;
    localparam int MAX_POLLS = 7;
    localparam int GAP_CYC   = 7;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         req_valid, req_ready, done, timeout;
    logic [13:0]  req_cmd;
    logic [31:0]  req_arg;
    logic [4:0]   status;
    logic [119:0] resp;
    logic [7:0]   wb_addr;
    logic [31:0]  wb_dout, wb_din;
    logic [3:0]   wb_dm;
    logic         wb_cyc, wb_stb, wb_we, wb_ack;

    always #5 clk = ~clk;

    sdc_cmd_master #(.POLL_W(POLL_W), .GAP_W(GAP_W), .READ_RESP(1)) dut (
        .clk(clk), .rst(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_cmd(req_cmd), .req_arg(req_arg),
        .done(done), .status(status), .timeout(timeout), .resp(resp),
        .wb_addr(wb_addr), .wb_dout(wb_dout), .wb_din(wb_din), .wb_dm(wb_dm),
        .wb_cyc(wb_cyc), .wb_stb(wb_stb), .wb_we(wb_we), .wb_ack(wb_ack)
    );

    typedef struct packed {
        logic        we;
        logic [7:0]  addr;
        logic [31:0] data;
        logic [15:0] gap;
        logic [15:0] len;
    } txn_t;

    txn_t         log_q[$];
    txn_t         exp_q[$];
    int           checks = 0;
    int           errors = 0;
    int           slv_waits = 0;
    int           wcnt, ev_idx;
    logic [31:0]  ev_arr[16];
    logic [31:0]  rw[4];
    logic [4:0]   exp_status;
    logic         exp_to;
    logic [119:0] exp_resp;
    int           base_log, base_done, base_stab;

    // ---------------- slave model ----------------
    assign wb_ack = wb_cyc && wb_stb && (wcnt == slv_waits);

    always_comb begin
        wb_din = '0;
        if (wb_cyc && !wb_we) begin
            if (wb_addr == 8'h34)
                wb_din = (ev_idx < 16) ? ev_arr[ev_idx] : 32'h0;
            else if (wb_addr >= 8'h08 && wb_addr <= 8'h14 && wb_addr[1:0] == 2'b00)
                wb_din = rw[int'(wb_addr[4:2]) - 2];
        end
    end

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wcnt   <= 0;
            ev_idx <= 0;
        end else begin
            if (req_valid && req_ready)
                ev_idx <= 0;
            else if (wb_ack && !wb_we && wb_addr == 8'h34)
                ev_idx <= ev_idx + 1;
            if (wb_cyc && wb_stb && !wb_ack) wcnt <= wcnt + 1;
            else                             wcnt <= 0;
        end
    end

    // ---------------- bus monitor ----------------
    int          cur_len = 0, idle = 0, stab_err = 0, done_cnt = 0;
    logic        cap_we;
    logic [7:0]  cap_addr;
    logic [31:0] cap_dout;
    logic [15:0] cap_gap;
    logic        mon_bad;

    assign mon_bad = (wb_dm != 4'hF) ||
                     ((wb_cyc && wb_stb) ?
                        ((cur_len != 0 && {wb_we, wb_addr, wb_dout} != {cap_we, cap_addr, cap_dout}) ||
                         (!wb_we && wb_dout != 32'h0)) :
                        (wb_cyc || wb_stb || wb_we));

    always @(negedge clk) begin
        if (!rst_n) begin
            cur_len <= 0;
            idle    <= 0;
        end else begin
            if (mon_bad) stab_err <= stab_err + 1;
            if (done)    done_cnt <= done_cnt + 1;
            if (wb_cyc && wb_stb) begin
                if (cur_len == 0) begin
                    cap_we   <= wb_we;
                    cap_addr <= wb_addr;
                    cap_dout <= wb_dout;
                    cap_gap  <= idle[15:0];
                end
                if (wb_ack) begin
                    log_q.push_back({wb_we, wb_addr, wb_we ? wb_dout : wb_din,
                                     (cur_len == 0) ? idle[15:0] : cap_gap, cur_len[15:0] + 16'd1});
                    cur_len <= 0;
                    idle    <= 0;
                end else begin
                    cur_len <= cur_len + 1;
                end
            end else begin
                idle <= idle + 1;
            end
        end
    end

    // ---------------- checking and reference model ----------------
    task automatic check_val(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic txn_t mk(input logic we, input logic [7:0] addr, input logic [31:0] data,
                                input int gap);
        txn_t t;
        t.we = we; t.addr = addr; t.data = data; t.gap = gap[15:0]; t.len = 16'd0;
        return t;
    endfunction

    // Builds slave contents and the expected transaction list for one request:
    // nz zero-event polls, then final event evf (evf==0 means never completes).
    task automatic prep(input logic [13:0] cmd, input logic [31:0] arg, input int nz,
                        input logic [4:0] evf);
        int   polls;
        logic [31:0] e;
        for (int i = 0; i < 16; i++) begin
            e = $urandom;
            ev_arr[i] = {e[31:5], (i < nz) ? 5'd0 : evf};
        end
        for (int k = 0; k < 4; k++) rw[k] = $urandom;
        exp_q.delete();
        exp_q.push_back(mk(1'b1, 8'h04, {18'b0, cmd}, 1));
        exp_q.push_back(mk(1'b1, 8'h00, arg, 1));
        polls = 0; exp_to = 1'b0; exp_status = 5'd0;
        while (1) begin
            e = ev_arr[polls];
            exp_q.push_back(mk(1'b0, 8'h34, e, (polls > 0) ? GAP_CYC : 1));
            polls++;
            if (e[4:0] != 5'd0) begin exp_status = e[4:0]; break; end
            if (polls == MAX_POLLS) begin exp_to = 1'b1; break; end
        end
        exp_q.push_back(mk(1'b1, 8'h34, 32'h0, 1));
        exp_resp = '0;
        if (!exp_to && exp_status[4:1] == 4'd0) begin
            for (int k = 0; k < 4; k++)
                exp_q.push_back(mk(1'b0, 8'h08 + 8'(4 * k), rw[k], 1));
            exp_resp = {rw[3][23:0], rw[2], rw[1], rw[0]};
        end
    endtask

    task automatic mark();
        base_log  = log_q.size();
        base_done = done_cnt;
        base_stab = stab_err;
    endtask

    task automatic launch(input logic [13:0] cmd, input logic [31:0] arg);
        for (int n = 0; n < 200 && !req_ready; n++) begin @(negedge clk); #1; end
        check_val("ready_before_req", req_ready, 1);
        mark();
        req_valid = 1'b1; req_cmd = cmd; req_arg = arg;
        @(posedge clk); #1;
        req_valid = 1'b0; req_cmd = 14'($urandom); req_arg = $urandom;
        check_val("clear_at_accept", {status, timeout, resp}, 0);
        check_val("busy_after_accept", req_ready, 0);
    endtask

    task automatic finish_txn(input string tag, input bit churn, input bit hold);
        bit got = 0;
        int n_log;
        for (int n = 0; n < 3000 && !got; n++) begin
            @(negedge clk); #1;
            got = done;
            if (churn && !got) begin req_arg = $urandom; req_cmd = 14'($urandom); end
        end
        check_val({tag, "_done_seen"}, got, 1);
        if (!got) return;
        check_val({tag, "_status"}, status, exp_status);
        check_val({tag, "_timeout"}, timeout, exp_to);
        check_val({tag, "_resp"}, resp, exp_resp);
        n_log = log_q.size() - base_log;
        check_val({tag, "_txn_count"}, n_log, exp_q.size());
        for (int i = 0; i < exp_q.size() && i < n_log; i++) begin
            txn_t o = log_q[base_log + i];
            check_val($sformatf("%s_txn%0d", tag, i), {o.we, o.addr, o.data},
                      {exp_q[i].we, exp_q[i].addr, exp_q[i].data});
            if (i > 0) check_val($sformatf("%s_gap%0d", tag, i), o.gap, exp_q[i].gap);
            check_val($sformatf("%s_len%0d", tag, i), o.len, slv_waits + 1);
        end
        check_val({tag, "_bus_rules"}, stab_err - base_stab, 0);
        @(negedge clk); #1;
        check_val({tag, "_done_pulse"}, {done, req_ready}, 2'b01);
        check_val({tag, "_done_count"}, done_cnt - base_done, 1);
        if (hold) begin
            repeat (3) begin @(negedge clk); #1; end
            check_val({tag, "_hold"}, {status, timeout, resp}, {exp_status, exp_to, exp_resp});
        end
    endtask

    task automatic chk_reset(input string tag);
        check_val({tag, "_bus"}, {wb_cyc, wb_stb, wb_we, wb_addr, wb_dout, done, req_ready}, 1);
        check_val({tag, "_out"}, {status, timeout, resp}, 0);
    endtask

    // ---------------- scenarios ----------------
    initial begin
        bit got;
        logic [13:0] c1;
        logic [31:0] a1;
        req_valid = 1'b0; req_cmd = '0; req_arg = '0;
        repeat (3) @(negedge clk);
        #1;
        chk_reset("reset");
        rst_n = 1'b1;
        @(negedge clk); #1;

        // nominal zero-wait command
        slv_waits = 0;
        prep(14'h0251, 32'h0000_1000, 2, 5'h01);
        launch(14'h0251, 32'h0000_1000);
        finish_txn("nominal", 0, 1);

        // error completion skips response reads
        c1 = 14'($urandom); a1 = $urandom;
        prep(c1, a1, 0, 5'h05);
        launch(c1, a1);
        finish_txn("error", 0, 1);

        // poll budget exhausted
        c1 = 14'($urandom); a1 = $urandom;
        prep(c1, a1, 0, 5'h00);
        launch(c1, a1);
        finish_txn("timeout", 0, 1);

        // three wait states per transfer
        slv_waits = 3;
        prep(14'h0251, 32'h0000_1000, 2, 5'h01);
        launch(14'h0251, 32'h0000_1000);
        finish_txn("waits", 0, 1);

        // reset during the poll gap
        slv_waits = 0;
        prep(14'h0011, 32'hA5A5_0001, 5, 5'h01);
        launch(14'h0011, 32'hA5A5_0001);
        got = 0;
        for (int n = 0; n < 200 && !got; n++) begin
            @(negedge clk); #1;
            got = (log_q.size() >= base_log + 3);
        end
        check_val("rst_gap_reached", got, 1);
        @(negedge clk); #1;
        @(negedge clk); #2;
        rst_n = 1'b0;
        #1;
        chk_reset("rst_in_gap");
        repeat (2) @(negedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk); #1;
        check_val("rst_no_done", done_cnt - base_done, 0);
        c1 = 14'($urandom); a1 = $urandom;
        prep(c1, a1, 1, 5'h01);
        launch(c1, a1);
        finish_txn("after_rst", 0, 1);

        // reset in the middle of a stretched bus cycle
        slv_waits = 3;
        prep(14'h0022, 32'h1234_5678, 0, 5'h01);
        launch(14'h0022, 32'h1234_5678);
        got = 0;
        for (int n = 0; n < 50 && !got; n++) begin @(negedge clk); #1; got = wb_cyc; end
        check_val("rst_cyc_reached", got, 1);
        @(posedge clk); #2;
        rst_n = 1'b0;
        #1;
        chk_reset("rst_in_cycle");
        repeat (2) @(negedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk); #1;

        // busy rejection with a request held valid throughout
        slv_waits = 1;
        prep(14'h0333, 32'hCAFE_0001, 1, 5'h01);
        mark();
        req_valid = 1'b1; req_cmd = 14'h0333; req_arg = 32'hCAFE_0001;
        @(posedge clk); #1;
        finish_txn("busy", 1, 0);
        c1 = req_cmd; a1 = req_arg;
        prep(c1, a1, 0, 5'h01);
        mark();
        @(posedge clk); #1;
        req_valid = 1'b0;
        check_val("second_accept_clear", {status, timeout, resp}, 0);
        check_val("second_accept_busy", req_ready, 0);
        finish_txn("second", 0, 1);

        // randomized requests
        for (int r = 0; r < 6; r++) begin
            slv_waits = $urandom_range(0, 3);
            c1 = 14'($urandom); a1 = $urandom;
            prep(c1, a1, $urandom_range(0, 8), 5'($urandom_range(0, 31)));
            launch(c1, a1);
            finish_txn($sformatf("rand%0d", r), 0, 1);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
